// File: rtl/alu_hilo_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide engine.
// The execute stage is the master; the engine is the slave.
interface alu_hilo_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              cancel;
    logic              ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] reg_lo;
    logic [DATA_W-1:0] reg_hi;

    modport master (
        output start, op, data1, data2, cancel,
        input  ready, busy, done, reg_lo, reg_hi
    );

    modport slave (
        input  start, op, data1, data2, cancel,
        output ready, busy, done, reg_lo, reg_hi
    );
endinterface

// File: rtl/alu_hilo_unit.sv
// Iterative radix-2 multiply/divide engine that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide share one 2*DATA_W accumulator.
module alu_hilo_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input logic       clock,
    input logic       reset_n,
    alu_hilo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MULS = 3'd0;
    localparam logic [2:0] OP_MULU = 3'd1;
    localparam logic [2:0] OP_DIVS = 3'd2;
    localparam logic [2:0] OP_DIVU = 3'd3;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    function automatic logic [DATA_W-1:0] f_cneg_w(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] f_cneg_d(input logic neg, input logic [2*DATA_W-1:0] x);
        return neg ? (~x + 1'b1) : x;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_opnd;
    logic [DATA_W-1:0]   r_orig_a;
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_dz;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    logic                w_signed_op;
    logic                w_is_muldiv;
    logic                w_is_div_op;
    logic                w_sa;
    logic                w_sb;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_diff;
    logic                w_div_ge;
    logic [DATA_W-1:0]   w_div_rem;
    logic [2*DATA_W-1:0] w_div_next;
    logic [2*DATA_W-1:0] w_fix_prod;
    logic [DATA_W-1:0]   w_fix_quo;
    logic [DATA_W-1:0]   w_fix_rem;

    assign w_signed_op = (bus.op == OP_MULS) || (bus.op == OP_DIVS);
    assign w_is_muldiv = (bus.op <= OP_DIVU);
    assign w_is_div_op = (bus.op == OP_DIVS) || (bus.op == OP_DIVU);
    assign w_sa        = w_signed_op & bus.data1[DATA_W-1];
    assign w_sb        = w_signed_op & bus.data2[DATA_W-1];
    assign w_a_mag     = f_cneg_w(w_sa, bus.data1);
    assign w_b_mag     = f_cneg_w(w_sb, bus.data2);

    // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = ~w_div_diff[DATA_W];
    assign w_div_rem   = w_div_ge ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
    assign w_div_next  = {w_div_rem, r_acc[DATA_W-2:0], w_div_ge};

    assign w_fix_prod = f_cneg_d(r_neg_res, r_acc);
    assign w_fix_quo  = r_dz ? '1 : f_cneg_w(r_neg_res, r_acc[DATA_W-1:0]);
    assign w_fix_rem  = r_dz ? r_orig_a : f_cneg_w(r_neg_rem, r_acc[2*DATA_W-1:DATA_W]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_orig_a  <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (w_is_muldiv) begin
                            r_is_div  <= w_is_div_op;
                            r_neg_res <= w_sa ^ w_sb;
                            r_neg_rem <= w_sa;
                            r_dz      <= w_is_div_op && (bus.data2 == '0);
                            r_orig_a  <= bus.data1;
                            r_cnt     <= CNT_W'(DATA_W);
                            r_state   <= RUN;
                            if (w_is_div_op) begin
                                r_acc  <= {{DATA_W{1'b0}}, w_a_mag};
                                r_opnd <= w_b_mag;
                            end else begin
                                r_acc  <= {{DATA_W{1'b0}}, w_b_mag};
                                r_opnd <= w_a_mag;
                            end
                        end else if (bus.op == OP_MTHI) begin
                            r_hi <= bus.data1;
                        end else if (bus.op == OP_MTLO) begin
                            r_lo <= bus.data1;
                        end
                    end
                end
                RUN: begin
                    if (bus.cancel) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    // A flush in the finalize cycle wins over the commit.
                    if (!bus.cancel) begin
                        if (r_is_div) begin
                            r_lo <= w_fix_quo;
                            r_hi <= w_fix_rem;
                        end else begin
                            r_lo <= w_fix_prod[DATA_W-1:0];
                            r_hi <= w_fix_prod[2*DATA_W-1:DATA_W];
                        end
                        r_done <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.ready  = (r_state == IDLE);
    assign bus.done   = r_done;
    assign bus.reg_lo = r_lo;
    assign bus.reg_hi = r_hi;
endmodule

// File: tb/tb_alu_hilo_unit.sv
// Randomized and directed bench for alu_hilo_unit against an arithmetic HI/LO reference model.
module tb_alu_hilo_unit;
    localparam int DATA_W = 32;

    logic clock;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_hilo_if #(.DATA_W(DATA_W)) bus ();

    alu_hilo_unit #(.DATA_W(DATA_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: results derived directly from integer arithmetic on the operands.
    task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        int          ia;
        int          ib;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                {m_hi, m_lo} = sp;
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = up;
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    ia = a; ib = b;
                    m_lo = ia / ib;
                    m_hi = ia % ib;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issues a mul/div at the current negedge and returns at the negedge where done is seen.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
        logic [31:0] p_hi;
        logic [31:0] p_lo;
        int          nbusy;
        int          c_done;
        chk("ready_at_issue", bus.ready, 1'b1);
        p_hi = m_hi;
        p_lo = m_lo;
        ref_apply(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
        nbusy  = 0;
        c_done = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            bus.start = (c == poke);
            if (c == poke) begin
                bus.op    = 3'($urandom_range(0, 5));
                bus.data1 = $urandom;
                bus.data2 = $urandom;
            end
            if (bus.done) begin
                c_done = c;
                break;
            end
            if (bus.busy) nbusy++;
            chk("hold_hi", bus.reg_hi, p_hi);
            chk("hold_lo", bus.reg_lo, p_lo);
        end
        chk("done_latency", c_done, DATA_W + 2);
        chk("busy_cycles", nbusy, DATA_W + 1);
        chk("busy_in_done", bus.busy, 1'b0);
        chk("res_hi", bus.reg_hi, m_hi);
        chk("res_lo", bus.reg_lo, m_lo);
    endtask

    task automatic run_move(input logic [2:0] op, input logic [31:0] a);
        ref_apply(op, a, 32'd0);
        bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = $urandom;
        @(negedge clock);
        bus.start = 1'b0;
        chk("mv_hi", bus.reg_hi, m_hi);
        chk("mv_lo", bus.reg_lo, m_lo);
        chk("mv_busy", bus.busy, 1'b0);
        chk("mv_done", bus.done, 1'b0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          saw_done;
        bus.start = 1'b0; bus.op = 3'd0; bus.data1 = '0; bus.data2 = '0; bus.cancel = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_hi", bus.reg_hi, 32'd0);
        chk("rst_lo", bus.reg_lo, 32'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ready", bus.ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("t1_hi", bus.reg_hi, 32'hFFFF_FFFE);
        chk("t1_lo", bus.reg_lo, 32'h0000_0001);
        @(negedge clock);
        chk("t1_done_once", bus.done, 1'b0);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        chk("t2m_lo", bus.reg_lo, 32'hFFFF_FFFA);
        @(negedge clock);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        chk("t2d_lo", bus.reg_lo, 32'hFFFF_FFFD);
        chk("t2d_hi", bus.reg_hi, 32'hFFFF_FFFF);
        @(negedge clock);

        run_op(3'd3, 32'd100, 32'd0, 0);
        chk("t3z_lo", bus.reg_lo, 32'hFFFF_FFFF);
        chk("t3z_hi", bus.reg_hi, 32'd100);
        @(negedge clock);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("t3o_lo", bus.reg_lo, 32'h8000_0000);
        chk("t3o_hi", bus.reg_hi, 32'd0);
        @(negedge clock);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 0);
        @(negedge clock);

        run_move(3'd4, 32'h1234_5678);
        run_move(3'd5, 32'h9ABC_DEF0);
        chk("t4_hi", bus.reg_hi, 32'h1234_5678);
        run_op(3'd3, 32'd1000, 32'd7, 5);
        @(negedge clock);

        // Cancel in IDLE together with start: the request is dropped.
        bus.start = 1'b1; bus.op = 3'd4; bus.data1 = 32'hDEAD_BEEF; bus.cancel = 1'b1;
        @(negedge clock);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("idle_cancel_hi", bus.reg_hi, m_hi);
        chk("idle_cancel_busy", bus.busy, 1'b0);

        // Flush mid-multiply: no commit, no done.
        bus.start = 1'b1; bus.op = 3'd1; bus.data1 = 32'd7; bus.data2 = 32'd6;
        saw_done = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clock);
            bus.start  = 1'b0;
            bus.cancel = (c == 10);
            if (c == 11) begin
                chk("cancel_busy", bus.busy, 1'b0);
                chk("cancel_hi", bus.reg_hi, m_hi);
                chk("cancel_lo", bus.reg_lo, m_lo);
            end
            if (bus.done) saw_done = 1'b1;
        end
        chk("cancel_no_done", saw_done, 1'b0);
        chk("cancel_final_lo", bus.reg_lo, m_lo);

        // Asynchronous reset in the middle of an operation.
        bus.start = 1'b1; bus.op = 3'd2; bus.data1 = 32'hFFFF_0000; bus.data2 = 32'd3;
        repeat (6) @(negedge clock);
        bus.start = 1'b0;
        chk("midrun_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("arst_hi", bus.reg_hi, 32'd0);
        chk("arst_lo", bus.reg_lo, 32'd0);
        chk("arst_busy", bus.busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(3'd3, 32'd17, 32'd5, 0);
        chk("b2b1_lo", bus.reg_lo, 32'd3);
        chk("b2b1_hi", bus.reg_hi, 32'd2);
        run_op(3'd1, 32'd3, 32'd4, 0);
        chk("b2b2_lo", bus.reg_lo, 32'd12);
        chk("b2b2_hi", bus.reg_hi, 32'd0);
        @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_val();
            b  = rnd_val();
            if (op <= 3'd3) begin
                run_op(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
                @(negedge clock);
                chk("rnd_done_pulse", bus.done, 1'b0);
            end else begin
                run_move(op, a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
